// File: rtl/uart_frame_arbiter_if.sv
// Requester-side and serializer-side signals of the UART frame arbiter.
// master = frame formatters plus uarttx status; slave = the arbiter.
interface uart_frame_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic [7:0]           tx_data;
  logic                 tx_wrsig;
  logic                 tx_busy;
  logic                 frame_done;
  logic                 tx_err;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant, tx_data, tx_wrsig, frame_done, tx_err
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, tx_data, tx_wrsig, frame_done, tx_err
  );
endinterface

// File: rtl/uart_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one uarttx serializer between NUM_REQ sources.
// Optional handshake timeout in WAIT_S is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_frame_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 32
) (
  input logic                 clk,
  input logic                 reset,
  uart_frame_arbiter_if.slave bus
);
  localparam int                   PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0]        LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]   ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_S, WAIT_D, GAP} state_t;

  state_t             state_reg, state_next;
  logic [PW-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [PW-1:0]      owner_reg, owner_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [7:0]         tx_data_reg, tx_data_next;
  logic [7:0]         gap_cnt_reg, gap_cnt_next;
  logic               last_reg, last_next;
  logic               frame_done_reg, frame_done_next;

  logic [7:0]         req_byte [NUM_REQ];
  logic               pick_found;
  logic [PW-1:0]      pick_idx;
  logic [PW-1:0]      owner_inc;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_byte[gi] = bus.req_data[8*gi +: 8];
    end
  endgenerate

  // Search for a valid requester starting at rr_ptr, wrapping explicitly at NUM_REQ.
  always_comb begin
    int            cand;
    logic [PW-1:0] cand_idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = cand[PW-1:0];
      if (!pick_found && bus.req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign owner_inc = (owner_reg == LAST_IDX) ? '0 : owner_reg + PW'(1);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int            CW        = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] ACK_LIMIT = CW'(ACK_TIMEOUT - 1);
  logic [CW-1:0] ack_cnt_reg, ack_cnt_next;
  logic          tx_err_reg, tx_err_next;
`endif

  always_comb begin
    state_next      = state_reg;
    rr_ptr_next     = rr_ptr_reg;
    owner_next      = owner_reg;
    grant_next      = grant_reg;
    tx_data_next    = tx_data_reg;
    last_next       = last_reg;
    gap_cnt_next    = gap_cnt_reg;
    frame_done_next = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    ack_cnt_next    = ack_cnt_reg;
    tx_err_next     = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          owner_next = pick_idx;
          grant_next = ONE_HOT0 << pick_idx;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (bus.req_valid[owner_reg]) begin
          tx_data_next = req_byte[owner_reg];
          last_next    = bus.req_last[owner_reg];
          state_next   = STROBE;
`ifdef UART_ARB_TIMEOUT_EN
          ack_cnt_next = '0;
`endif
        end
      end
      STROBE: begin
        state_next = WAIT_S;
`ifdef UART_ARB_TIMEOUT_EN
        ack_cnt_next = ack_cnt_reg + CW'(1);
`endif
      end
      WAIT_S: begin
        // Busy sampled here is post-strobe; a stale level seen during STROBE is ignored.
        if (bus.tx_busy) begin
          state_next = WAIT_D;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (ack_cnt_reg >= ACK_LIMIT) begin
          tx_err_next = 1'b1;
          grant_next  = '0;
          rr_ptr_next = owner_inc;
          state_next  = IDLE;
        end else begin
          ack_cnt_next = ack_cnt_reg + CW'(1);
        end
`endif
      end
      WAIT_D: begin
        if (!bus.tx_busy) begin
          gap_cnt_next = 8'(GAP_CYCLES);
          state_next   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_reg == 8'd0) begin
          if (last_reg) begin
            frame_done_next = 1'b1;
            grant_next      = '0;
            rr_ptr_next     = owner_inc;
            state_next      = IDLE;
          end else begin
            state_next = LOAD;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg - 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      owner_reg      <= '0;
      grant_reg      <= '0;
      tx_data_reg    <= 8'd0;
      gap_cnt_reg    <= 8'd0;
      last_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rr_ptr_reg     <= rr_ptr_next;
      owner_reg      <= owner_next;
      grant_reg      <= grant_next;
      tx_data_reg    <= tx_data_next;
      gap_cnt_reg    <= gap_cnt_next;
      last_reg       <= last_next;
      frame_done_reg <= frame_done_next;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_cnt_reg <= '0;
      tx_err_reg  <= 1'b0;
    end else begin
      ack_cnt_reg <= ack_cnt_next;
      tx_err_reg  <= tx_err_next;
    end
  end
  assign bus.tx_err = tx_err_reg;
`else
  assign bus.tx_err = 1'b0;
`endif

  assign bus.grant      = grant_reg;
  assign bus.req_ready  = (state_reg == LOAD) ? grant_reg : '0;
  assign bus.tx_data    = tx_data_reg;
  assign bus.tx_wrsig   = (state_reg == STROBE);
  assign bus.frame_done = frame_done_reg;

endmodule
